mem_addr_gen: RTL and testbench
===============================

Name: mem_addr_gen

Overview:
Address generator between the accelerator controller and the data/result memories.
- Holds three pointers: filter read pointer y, sliding-window input pointer x, result write pointer z.
- Advances them on the controller's yEn/xEn/zEn strobes.
- Drives the muxed data-memory address and the result-memory address.
- Reports end-of-window and exhaustion flags back to the controller.

Parameters:
ADDR_W, 16, width of all memory addresses
FILT_BASE, 0, data-memory address of first filter word
FILT_WORDS, 16, total filter words to load (N PEs x 4 words)
IFMAP_BASE, 64, data-memory address of first input-map word
IFMAP_LEN, 64, input-map length in words
WIN, 4, window length in words (equals filter length)
STRIDE, 1, window advance in words
RES_BASE, 0, result-memory address of first result
RES_DEPTH, 61, result slots available; default equals window count (IFMAP_LEN-WIN)/STRIDE+1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
startIn  in  1  one-cycle pulse: reload all pointers and enter ACTIVE
yEnIn  in  1  advance filter pointer
xEnIn  in  1  advance input-window pointer
zEnIn  in  1  advance result pointer
dataMemAddrSelIn  in  1  0 selects filter address, 1 selects input address
dataMemAddrOut  out  ADDR_W  data-memory read address
resMemAddrOut  out  ADDR_W  result-memory write address
winEndOut  out  1  current x address is the last word of its window
filtDoneOut  out  1  all FILT_WORDS filter words have been consumed
ifmapDoneOut  out  1  no further full window exists
resFullOut  out  1  RES_DEPTH results have been written
activeOut  out  1  FSM is in ACTIVE

Behaviour:
- All state is updated on posedge clk. Reset is synchronous and active-high.
- Reset values:
  - FSM = IDLE.
  - y = 0, wb (window base) = 0, off (window offset) = 0, z = 0.
  - All flags = 0, activeOut = 0.
  - dataMemAddrOut = FILT_BASE, resMemAddrOut = RES_BASE.
- FSM:
  - IDLE -> ACTIVE on startIn.
  - ACTIVE -> DONE when filtDone & ifmapDone & resFull are all set.
  - DONE -> ACTIVE on startIn.
  - rst -> IDLE from any state, mid-operation included.
- Enables are honoured only in ACTIVE; in IDLE and DONE they are ignored.
- startIn:
  - Clears y, wb, off, z and all flags on the next edge.
  - Has priority over any enable asserted in the same cycle (that enable is dropped).
  - startIn while already in ACTIVE restarts the pass.
- Filter pointer (y):
  - yEn with filtDone = 0: y <= y+1.
  - filtDone sets on the edge that consumes word FILT_WORDS-1.
  - y saturates at FILT_WORDS-1. yEn while filtDone = 1 is ignored.
- Input pointer (x):
  - xEn with ifmapDone = 0 and off < WIN-1: off <= off+1.
  - xEn with off = WIN-1: off <= 0, wb <= wb+STRIDE. If (wb+STRIDE)+WIN > IFMAP_LEN, ifmapDone sets and wb/off hold their old values.
  - xEn while ifmapDone = 1 is ignored.
- Result pointer (z):
  - zEn with resFull = 0: z <= z+1.
  - resFull sets when the count reaches RES_DEPTH; further zEn is ignored.
- Outputs:
  - dataMemAddrOut (combinational): sel ? IFMAP_BASE+wb+off : FILT_BASE+y.
  - resMemAddrOut (combinational) = RES_BASE+z.
  - winEndOut (combinational) = (off == WIN-1) & ~ifmapDone.
- Latency: an enable sampled at edge k gives the new address in the cycle after k, so the memory read for the new address occurs in cycle k+1.
- Simultaneous yEn/xEn/zEn: all three advance independently in the same cycle.
- Arithmetic: unsigned, ADDR_W bits. Parameter sets must not overflow ADDR_W; no wrap is required.

Test Plan:
- Reset and idle: rst 1 cycle, then xEn/yEn/zEn pulses in IDLE -> all pointers stay 0, dataMemAddrOut = 0, flags = 0, activeOut = 0.
- Filter load: startIn, then 16 yEn with sel = 0 -> addresses 0..15. filtDone rises after the 16th. A 17th yEn leaves the address at 15.
- Window walk (IFMAP_LEN = 8, WIN = 4, STRIDE = 2, sel = 1):
  - 12 xEn -> addresses 64,65,66,67, 66..69, 68..71.
  - winEndOut is high at 67, 69 and 71.
  - ifmapDone rises after the 12th xEn; a 13th xEn leaves the address at 71.
- Result fill (RES_DEPTH = 3): 3 zEn -> resMemAddrOut 0,1,2 then 3 with resFull = 1. A 4th zEn -> no change. With filtDone and ifmapDone also set, the FSM moves to DONE.
- Priority/restart: startIn with yEn and xEn in the same cycle mid-pass -> all pointers and flags clear, no advance. Then rst mid-pass -> IDLE, all reset values.

Source files
------------

// File: rtl/mem_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : mem_addr_gen
// Brief    : Filter, input-window and result pointers driving the data- and
//            result-memory addresses for the accelerator controller.
// Revision : 1.0 - initial release
// ============================================================================
module mem_addr_gen #(
  parameter int ADDR_W     = 16,
  parameter int FILT_BASE  = 0,
  parameter int FILT_WORDS = 16,
  parameter int IFMAP_BASE = 64,
  parameter int IFMAP_LEN  = 64,
  parameter int WIN        = 4,
  parameter int STRIDE     = 1,
  parameter int RES_BASE   = 0,
  parameter int RES_DEPTH  = 61
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startIn,
  input  logic              yEnIn,
  input  logic              xEnIn,
  input  logic              zEnIn,
  input  logic              dataMemAddrSelIn,
  output logic [ADDR_W-1:0] dataMemAddrOut,
  output logic [ADDR_W-1:0] resMemAddrOut,
  output logic              winEndOut,
  output logic              filtDoneOut,
  output logic              ifmapDoneOut,
  output logic              resFullOut,
  output logic              activeOut
);

  localparam logic [ADDR_W-1:0] c_filt_base  = ADDR_W'(FILT_BASE);
  localparam logic [ADDR_W-1:0] c_filt_last  = ADDR_W'(FILT_WORDS - 1);
  localparam logic [ADDR_W-1:0] c_ifmap_base = ADDR_W'(IFMAP_BASE);
  localparam logic [ADDR_W-1:0] c_ifmap_len  = ADDR_W'(IFMAP_LEN);
  localparam logic [ADDR_W-1:0] c_win        = ADDR_W'(WIN);
  localparam logic [ADDR_W-1:0] c_win_last   = ADDR_W'(WIN - 1);
  localparam logic [ADDR_W-1:0] c_stride     = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] c_res_base   = ADDR_W'(RES_BASE);
  localparam logic [ADDR_W-1:0] c_res_last   = ADDR_W'(RES_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_y;
  logic [ADDR_W-1:0] r_wb;
  logic [ADDR_W-1:0] r_off;
  logic [ADDR_W-1:0] r_z;
  logic              r_filt_done;
  logic              r_ifmap_done;
  logic              r_res_full;

  logic              w_run;
  logic              w_y_adv;
  logic              w_x_adv;
  logic              w_z_adv;
  logic [ADDR_W-1:0] w_wb_nxt;
  logic [ADDR_W:0]   w_wb_end;
  logic              w_wb_over;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (startIn) w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (startIn) begin
          w_state_nxt = S_ACTIVE;
        end else if (r_filt_done && r_ifmap_done && r_res_full) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (startIn) w_state_nxt = S_ACTIVE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A start in the same cycle drops any enable.
  assign w_run   = (r_state == S_ACTIVE) && !startIn;
  assign w_y_adv = w_run && yEnIn && !r_filt_done;
  assign w_x_adv = w_run && xEnIn && !r_ifmap_done;
  assign w_z_adv = w_run && zEnIn && !r_res_full;

  // One extra bit so the next window's end is compared without wrap.
  assign w_wb_nxt  = r_wb + c_stride;
  assign w_wb_end  = {1'b0, w_wb_nxt} + {1'b0, c_win};
  assign w_wb_over = w_wb_end > {1'b0, c_ifmap_len};

  always_ff @(posedge clk) begin
    if (rst || startIn) begin
      r_y          <= '0;
      r_wb         <= '0;
      r_off        <= '0;
      r_z          <= '0;
      r_filt_done  <= 1'b0;
      r_ifmap_done <= 1'b0;
      r_res_full   <= 1'b0;
    end else begin
      if (w_y_adv) begin
        if (r_y == c_filt_last) begin
          r_filt_done <= 1'b1;
        end else begin
          r_y <= r_y + 1'b1;
        end
      end
      if (w_x_adv) begin
        if (r_off != c_win_last) begin
          r_off <= r_off + 1'b1;
        end else if (w_wb_over) begin
          r_ifmap_done <= 1'b1;
        end else begin
          r_off <= '0;
          r_wb  <= w_wb_nxt;
        end
      end
      if (w_z_adv) begin
        r_z <= r_z + 1'b1;
        if (r_z == c_res_last) r_res_full <= 1'b1;
      end
    end
  end

  assign dataMemAddrOut = dataMemAddrSelIn ? (c_ifmap_base + r_wb + r_off)
                                           : (c_filt_base + r_y);
  assign resMemAddrOut  = c_res_base + r_z;
  assign winEndOut      = (r_off == c_win_last) && !r_ifmap_done;
  assign filtDoneOut    = r_filt_done;
  assign ifmapDoneOut   = r_ifmap_done;
  assign resFullOut     = r_res_full;
  assign activeOut      = (r_state == S_ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_mem_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_addr_gen
// Brief    : Directed vector table plus restart/reset sequences for mem_addr_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_addr_gen;

  logic        clk;
  logic        rst;
  logic        startIn;
  logic        yEnIn;
  logic        xEnIn;
  logic        zEnIn;
  logic        dataMemAddrSelIn;
  logic [15:0] dataMemAddrOut;
  logic [15:0] resMemAddrOut;
  logic        winEndOut;
  logic        filtDoneOut;
  logic        ifmapDoneOut;
  logic        resFullOut;
  logic        activeOut;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst, start, y, x, z, sel;
    logic [15:0] data, res;
    logic        we, fd, id, rf, act;
  } vec_t;

  vec_t vq[$];

  mem_addr_gen #(
    .ADDR_W    (16),
    .FILT_BASE (0),
    .FILT_WORDS(16),
    .IFMAP_BASE(64),
    .IFMAP_LEN (8),
    .WIN       (4),
    .STRIDE    (2),
    .RES_BASE  (0),
    .RES_DEPTH (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .startIn         (startIn),
    .yEnIn           (yEnIn),
    .xEnIn           (xEnIn),
    .zEnIn           (zEnIn),
    .dataMemAddrSelIn(dataMemAddrSelIn),
    .dataMemAddrOut  (dataMemAddrOut),
    .resMemAddrOut   (resMemAddrOut),
    .winEndOut       (winEndOut),
    .filtDoneOut     (filtDoneOut),
    .ifmapDoneOut    (ifmapDoneOut),
    .resFullOut      (resFullOut),
    .activeOut       (activeOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic r, s, y, x, z, sel,
                     input logic [15:0] data, res,
                     input logic we, fd, id, rf, act);
    vec_t v;
    v.rst = r; v.start = s; v.y = y; v.x = x; v.z = z; v.sel = sel;
    v.data = data; v.res = res;
    v.we = we; v.fd = fd; v.id = id; v.rf = rf; v.act = act;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic drive(input logic r, s, y, x, z, sel);
    @(negedge clk);
    rst = r; startIn = s; yEnIn = y; xEnIn = x; zEnIn = z; dataMemAddrSelIn = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] data, res,
                         input logic we, fd, id, rf, act);
    chk({tag, ".data"},  dataMemAddrOut, data);
    chk({tag, ".res"},   resMemAddrOut, res);
    chk({tag, ".win"},   16'(winEndOut), 16'(we));
    chk({tag, ".filt"},  16'(filtDoneOut), 16'(fd));
    chk({tag, ".ifmap"}, 16'(ifmapDoneOut), 16'(id));
    chk({tag, ".full"},  16'(resFullOut), 16'(rf));
    chk({tag, ".act"},   16'(activeOut), 16'(act));
  endtask

  initial begin
    logic [15:0] xa[13] = '{65, 66, 67, 66, 67, 68, 69, 68, 69, 70, 71, 71, 71};
    logic        xw[13] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};

    rst = 1'b0; startIn = 1'b0; yEnIn = 1'b0; xEnIn = 1'b0; zEnIn = 1'b0;
    dataMemAddrSelIn = 1'b0;

    // Reset, then enables in IDLE are ignored
    add(1, 0, 0, 0, 0, 0,  16'd0,  16'd0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0,  16'd0,  16'd0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 1, 1,  16'd64, 16'd0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  16'd0,  16'd0, 0, 0, 0, 0, 1);
    // Filter load
    for (int i = 1; i <= 15; i++) add(0, 0, 1, 0, 0, 0, 16'(i), 16'd0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0,  16'd15, 16'd0, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0,  16'd15, 16'd0, 0, 1, 0, 0, 1);
    // Window walk
    add(0, 0, 0, 0, 0, 1,  16'd64, 16'd0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 13; i++) add(0, 0, 0, 1, 0, 1, xa[i], 16'd0, xw[i], 1, (i >= 11), 0, 1);
    // Result fill, then DONE
    add(0, 0, 0, 0, 1, 1,  16'd71, 16'd1, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 1, 1,  16'd71, 16'd2, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 1, 1,  16'd71, 16'd3, 0, 1, 1, 1, 1);
    add(0, 0, 0, 0, 1, 1,  16'd71, 16'd3, 0, 1, 1, 1, 0);
    add(0, 0, 1, 1, 1, 0,  16'd15, 16'd3, 0, 1, 1, 1, 0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].start, vq[i].y, vq[i].x, vq[i].z, vq[i].sel);
      chk_all($sformatf("v%0d", i), vq[i].data, vq[i].res,
              vq[i].we, vq[i].fd, vq[i].id, vq[i].rf, vq[i].act);
    end

    // Restart from DONE
    drive(0, 1, 0, 0, 0, 0);
    chk_all("restart", 16'd0, 16'd0, 0, 0, 0, 0, 1);

    // Simultaneous advance of all three pointers
    drive(0, 0, 1, 1, 1, 0);
    drive(0, 0, 1, 1, 1, 0);
    chk_all("simul_y", 16'd2, 16'd2, 0, 0, 0, 0, 1);
    dataMemAddrSelIn = 1'b1;
    #1;
    chk("simul_x.data", dataMemAddrOut, 16'd66);
    drive(0, 0, 0, 1, 0, 1);
    chk_all("simul_x3", 16'd67, 16'd2, 1, 0, 0, 0, 1);

    // Start wins over same-cycle enables
    drive(0, 1, 1, 1, 0, 1);
    chk_all("prio_x", 16'd64, 16'd0, 0, 0, 0, 0, 1);
    dataMemAddrSelIn = 1'b0;
    #1;
    chk("prio_y.data", dataMemAddrOut, 16'd0);

    // Reset mid-pass
    drive(0, 0, 1, 0, 1, 0);
    chk_all("pre_rst", 16'd1, 16'd1, 0, 0, 0, 0, 1);
    drive(1, 0, 1, 0, 1, 0);
    chk_all("rst_mid", 16'd0, 16'd0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 1, 0);
    chk_all("post_rst_idle", 16'd0, 16'd0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
